// File: rtl/svcs_hs_pkg.sv
// Shared definitions for the SVCS handshake receive path: data-type tags,
// frame geometry, FSM states and the decoded header layout.
package svcs_hs_pkg;

    // Type tags must stay bit-identical to svcs_dpi_hash("byte"/"int"/"real") on the software side.
    localparam logic [63:0] SVCS_DT_BYTE = 64'h9A3C_5E1F_0B27_D481;
    localparam logic [63:0] SVCS_DT_INT  = 64'h4E2D_71A8_C3F0_96B5;
    localparam logic [63:0] SVCS_DT_REAL = 64'h1F86_D4E3_A25B_7C09;

    localparam int unsigned SVCS_HDR_BYTES = 28;
    localparam int unsigned SVCS_MAX_SIZE  = 4096;

    typedef enum logic [1:0] {
        ST_HDR,
        ST_PAYLOAD,
        ST_ERR
    } svcs_state_e;

    // Field order puts trnx_type in the low bits, matching little-endian arrival order.
    typedef struct packed {
        logic [31:0] n_payloads;
        logic [63:0] data_type;
        logic [63:0] trnx_id;
        logic [63:0] trnx_type;
    } svcs_hdr_t;

    function automatic logic [3:0] svcs_elem_size(input logic [63:0] data_type);
        logic [3:0] size;
        size = 4'd0;
        if (data_type == SVCS_DT_BYTE) size = 4'd1;
        if (data_type == SVCS_DT_INT)  size = 4'd4;
        if (data_type == SVCS_DT_REAL) size = 4'd8;
        return size;
    endfunction

endpackage

// File: rtl/svcs_hs_rx_deframer_if.sv
// Byte-stream input, decoded header and element-stream output of the SVCS
// receive deframer. The slave modport is the deframer's view.
interface svcs_hs_rx_deframer_if;

    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_byte;

    logic        hdr_valid;
    logic [63:0] hdr_trnx_type;
    logic [63:0] hdr_trnx_id;
    logic [63:0] hdr_data_type;
    logic [31:0] hdr_n_payloads;

    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        out_last;

    logic        err;
    logic        err_clr;

    modport master (
        output in_valid, in_byte, out_ready, err_clr,
        input  in_ready, hdr_valid, hdr_trnx_type, hdr_trnx_id, hdr_data_type,
               hdr_n_payloads, out_valid, out_data, out_last, err
    );

    modport slave (
        input  in_valid, in_byte, out_ready, err_clr,
        output in_ready, hdr_valid, hdr_trnx_type, hdr_trnx_id, hdr_data_type,
               hdr_n_payloads, out_valid, out_data, out_last, err
    );

endinterface

// File: rtl/svcs_byte_assembler.sv
// Little-endian field assembler: byte k of a field lands in bits [8k+7:8k].
// SVCS_RX_TIMEOUT_EN adds a busy flag used by the deframer's idle timer.
module svcs_byte_assembler #(
    parameter int unsigned MAX_BYTES = 28,
    localparam int unsigned CW = $clog2(MAX_BYTES + 1),
    localparam int unsigned W  = MAX_BYTES * 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          shift_en,
    input  logic [7:0]    byte_in,
    input  logic [CW-1:0] num_bytes,
    output logic [W-1:0]  word,
    output logic          done
`ifdef SVCS_RX_TIMEOUT_EN
    ,
    output logic          busy
`endif
);

    logic [CW-1:0] count;
    logic [W-1:0]  acc;

    // acc is cleared between fields, so word is already zero above the current field width.
    assign word = acc | (W'(byte_in) << {count, 3'b000});
    assign done = shift_en && (count == num_bytes - CW'(1));

`ifdef SVCS_RX_TIMEOUT_EN
    assign busy = (count != '0);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            acc   <= '0;
        end else if (clear) begin
            count <= '0;
            acc   <= '0;
        end else if (shift_en) begin
            if (done) begin
                count <= '0;
                acc   <= '0;
            end else begin
                count <= count + CW'(1);
                acc   <= word;
            end
        end
    end

endmodule

// File: rtl/svcs_hs_rx_deframer.sv
// SVCS handshake receive deframer: byte stream -> decoded header + element stream.
// Define SVCS_RX_TIMEOUT_EN to abort stalled frames after TIMEOUT_CYCLES idle cycles.
module svcs_hs_rx_deframer
    import svcs_hs_pkg::*;
#(
    parameter int unsigned MAX_PAYLOADS = SVCS_MAX_SIZE
`ifdef SVCS_RX_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 1024
`endif
) (
    input logic                  clk,
    input logic                  rst,
    svcs_hs_rx_deframer_if.slave bus
);

    localparam int unsigned ASM_CW = $clog2(SVCS_HDR_BYTES + 1);

    svcs_state_e               state;
    svcs_hdr_t                 hdr_q;
    svcs_hdr_t                 hdr_next;
    logic                      hdr_valid_q;
    logic                      out_valid_q;
    logic [63:0]               out_data_q;
    logic                      out_last_q;
    logic                      err_q;
    logic [3:0]                elem_size;
    logic [3:0]                hdr_size;
    logic [31:0]               elem_idx;
    logic                      elem_is_last;
    logic                      in_ready;
    logic                      accept;
    logic                      asm_shift;
    logic                      asm_clear;
    logic                      asm_done;
    logic [ASM_CW-1:0]         asm_len;
    logic [SVCS_HDR_BYTES*8-1:0] asm_word;

    // In PAYLOAD the single output register acts as the skid: a byte may enter only if the slot frees this cycle.
    always_comb begin
        in_ready = 1'b1;
        if (state == ST_PAYLOAD) in_ready = !out_valid_q || bus.out_ready;
    end

    assign accept       = bus.in_valid && in_ready;
    assign asm_shift    = accept && (state != ST_ERR);
    assign asm_clear    = (state == ST_ERR);
    assign asm_len      = (state == ST_PAYLOAD) ? ASM_CW'(elem_size) : ASM_CW'(SVCS_HDR_BYTES);
    assign hdr_next     = svcs_hdr_t'(asm_word);
    assign hdr_size     = svcs_elem_size(hdr_next.data_type);
    assign elem_is_last = (elem_idx == hdr_q.n_payloads - 32'd1);

`ifdef SVCS_RX_TIMEOUT_EN
    localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    logic              asm_busy;
    logic              in_progress;
    logic [IDLE_W-1:0] idle_cnt;

    assign in_progress = (state == ST_PAYLOAD) || ((state == ST_HDR) && asm_busy);
`endif

    svcs_byte_assembler #(
        .MAX_BYTES (SVCS_HDR_BYTES)
    ) u_asm (
        .clk       (clk),
        .rst       (rst),
        .clear     (asm_clear),
        .shift_en  (asm_shift),
        .byte_in   (bus.in_byte),
        .num_bytes (asm_len),
        .word      (asm_word),
        .done      (asm_done)
`ifdef SVCS_RX_TIMEOUT_EN
        ,
        .busy      (asm_busy)
`endif
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_HDR;
            hdr_q       <= '0;
            hdr_valid_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            err_q       <= 1'b0;
            elem_size   <= 4'd1;
            elem_idx    <= '0;
`ifdef SVCS_RX_TIMEOUT_EN
            idle_cnt    <= '0;
`endif
        end else begin
            hdr_valid_q <= 1'b0;
            if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end

            case (state)
                ST_HDR: begin
                    if (asm_done) begin
                        hdr_q       <= hdr_next;
                        hdr_valid_q <= 1'b1;
                        elem_size   <= hdr_size;
                        elem_idx    <= '0;
                        if (hdr_size == 4'd0 || hdr_next.n_payloads > MAX_PAYLOADS) begin
                            state <= ST_ERR;
                            err_q <= 1'b1;
                        end else if (hdr_next.n_payloads != 32'd0) begin
                            state <= ST_PAYLOAD;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (asm_done) begin
                        out_valid_q <= 1'b1;
                        out_data_q  <= asm_word[63:0];
                        out_last_q  <= elem_is_last;
                        elem_idx    <= elem_idx + 32'd1;
                        if (elem_is_last) state <= ST_HDR;
                    end
                end
                ST_ERR: begin
                    if (bus.err_clr) begin
                        state <= ST_HDR;
                        err_q <= 1'b0;
                    end
                end
                default: state <= ST_HDR;
            endcase

`ifdef SVCS_RX_TIMEOUT_EN
            // A byte offered but held off by out_ready is not idle time; the counter just holds.
            if (accept || !in_progress) begin
                idle_cnt <= '0;
            end else if (!bus.in_valid) begin
                if (idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1)) begin
                    idle_cnt <= '0;
                    state    <= ST_ERR;
                    err_q    <= 1'b1;
                end else begin
                    idle_cnt <= idle_cnt + IDLE_W'(1);
                end
            end
`endif
        end
    end

    assign bus.in_ready       = in_ready;
    assign bus.hdr_valid      = hdr_valid_q;
    assign bus.hdr_trnx_type  = hdr_q.trnx_type;
    assign bus.hdr_trnx_id    = hdr_q.trnx_id;
    assign bus.hdr_data_type  = hdr_q.data_type;
    assign bus.hdr_n_payloads = hdr_q.n_payloads;
    assign bus.out_valid      = out_valid_q;
    assign bus.out_data       = out_data_q;
    assign bus.out_last       = out_last_q;
    assign bus.err            = err_q;

endmodule
